// File: rtl/compressed_stream_loader.sv
// compressed_stream_loader: queues 16-bit host words in a small FIFO and writes them byte-wise
// (high byte first) to RAM through the DMA write port. Define LOADER_CHECKSUM_EN to add a byte checksum output.
module compressed_stream_loader #(
  parameter logic [15:0] BASE_ADDR  = 16'h0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        load,
  input  logic        interrupt,
  input  logic [15:0] Din,
  input  logic        dinValid,
  output logic        dinReady,
  output logic [15:0] ramAddress,
  output logic [7:0]  ramDataIn,
  output logic        ramWriteSignal,
  input  logic        ramDoneWrite,
  output logic [15:0] byteCount,
  output logic        loading,
  output logic        done,
  output logic        aborted
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [7:0]  checksum
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HEADER   = 3'd1,
    DATA     = 3'd2,
    WRITE_HI = 3'd3,
    WAIT_HI  = 3'd4,
    WRITE_LO = 3'd5,
    WAIT_LO  = 3'd6,
    DONE     = 3'd7
  } stateT;

  function automatic logic isBusy(input stateT s);
    return (s == DATA) || (s == WRITE_HI) || (s == WAIT_HI) || (s == WRITE_LO) || (s == WAIT_LO);
  endfunction

`ifdef LOADER_CHECKSUM_EN
  function automatic logic [7:0] addByte(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction
`endif

  stateT        stateR, nextStateS;
  logic         loadPrevR;
  logic [15:0]  lenR, owedR, owedNextS, halfUpS;
  logic [15:0]  fifoMemR [FIFO_DEPTH];
  logic [PW-1:0] wrPtrR, rdPtrR;
  logic [PW:0]  fifoCountR, countNextS;
  logic [15:0]  byteCountR, byteCountIncS, ramAddressR;
  logic [7:0]   ramDataInR, writeByteS;
  logic         ramWriteR, dinReadyR, loadingR, doneR, abortedR;
  logic         loadRiseS, acceptS, abortS, readyNextS;
  logic         pushS, popS, flushS, startS, hdrS, wrDoneS, loadWriteS;
  logic [15:0]  headDataS;

  assign loadRiseS     = load & ~loadPrevR;
  assign acceptS       = dinValid & dinReadyR;
  assign abortS        = interrupt & (stateR != IDLE);
  assign byteCountIncS = byteCountR + 16'h0001;
  assign headDataS     = fifoMemR[rdPtrR];
  // Words owed after the header: ceil(N/2), computed without overflow.
  assign halfUpS       = {1'b0, Din[15:1]} + {15'h0000, Din[0]};

  assign dinReady       = dinReadyR;
  assign ramAddress     = ramAddressR;
  assign ramDataIn      = ramDataInR;
  assign ramWriteSignal = ramWriteR;
  assign byteCount      = byteCountR;
  assign loading        = loadingR;
  assign done           = doneR;
  assign aborted        = abortedR;

  // Next-state decode; interrupt overrides everything, including a coincident load edge.
  always_comb begin
    nextStateS = stateR;
    pushS      = 1'b0;
    popS       = 1'b0;
    flushS     = 1'b0;
    startS     = 1'b0;
    hdrS       = 1'b0;
    wrDoneS    = 1'b0;
    loadWriteS = 1'b0;
    writeByteS = 8'h00;
    if (interrupt) begin
      flushS     = 1'b1;
      nextStateS = IDLE;
    end else begin
      pushS = acceptS & isBusy(stateR);
      case (stateR)
        IDLE, DONE: begin
          if (loadRiseS) begin
            nextStateS = HEADER;
            startS     = 1'b1;
          end else begin
            nextStateS = stateR;
          end
        end
        HEADER: begin
          if (acceptS) begin
            hdrS       = 1'b1;
            nextStateS = (Din == 16'h0000) ? DONE : DATA;
          end else begin
            nextStateS = HEADER;
          end
        end
        DATA: begin
          if (fifoCountR != {(PW+1){1'b0}}) begin
            nextStateS = WRITE_HI;
            loadWriteS = 1'b1;
            writeByteS = headDataS[15:8];
          end else begin
            nextStateS = DATA;
          end
        end
        WRITE_HI: nextStateS = WAIT_HI;
        WAIT_HI: begin
          if (ramDoneWrite) begin
            wrDoneS = 1'b1;
            if (byteCountIncS == lenR) begin
              popS       = 1'b1;
              nextStateS = DONE;
            end else begin
              nextStateS = WRITE_LO;
              loadWriteS = 1'b1;
              writeByteS = headDataS[7:0];
            end
          end else begin
            nextStateS = WAIT_HI;
          end
        end
        WRITE_LO: nextStateS = WAIT_LO;
        WAIT_LO: begin
          if (ramDoneWrite) begin
            wrDoneS    = 1'b1;
            popS       = 1'b1;
            nextStateS = (byteCountIncS == lenR) ? DONE : DATA;
          end else begin
            nextStateS = WAIT_LO;
          end
        end
        default: nextStateS = IDLE;
      endcase
    end
  end

  // FIFO occupancy, words still owed, and the registered ready it implies.
  always_comb begin
    countNextS = fifoCountR;
    owedNextS  = owedR;
    if (flushS) begin
      countNextS = {(PW+1){1'b0}};
      owedNextS  = 16'h0000;
    end else begin
      countNextS = fifoCountR + {{PW{1'b0}}, pushS} - {{PW{1'b0}}, popS};
      if (hdrS) begin
        owedNextS = halfUpS;
      end else if (pushS) begin
        owedNextS = owedR - 16'h0001;
      end else begin
        owedNextS = owedR;
      end
    end
    readyNextS = (nextStateS == HEADER) ||
                 (isBusy(nextStateS) && (countNextS < DEPTH_C) && (owedNextS != 16'h0000));
  end

  // Control state, counters and the registered DMA/status outputs.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      stateR      <= IDLE;
      loadPrevR   <= 1'b0;
      lenR        <= 16'h0000;
      owedR       <= 16'h0000;
      byteCountR  <= 16'h0000;
      ramAddressR <= 16'h0000;
      ramDataInR  <= 8'h00;
      ramWriteR   <= 1'b0;
      dinReadyR   <= 1'b0;
      loadingR    <= 1'b0;
      doneR       <= 1'b0;
      abortedR    <= 1'b0;
    end else begin
      stateR    <= nextStateS;
      loadPrevR <= load;
      owedR     <= owedNextS;
      dinReadyR <= readyNextS;
      loadingR  <= (nextStateS == HEADER) || isBusy(nextStateS);
      doneR     <= (nextStateS == DONE);
      abortedR  <= abortS;
      ramWriteR <= (nextStateS == WAIT_HI) || (nextStateS == WAIT_LO);
      if (hdrS) lenR <= Din;
      if (startS) begin
        byteCountR <= 16'h0000;
      end else if (wrDoneS) begin
        byteCountR <= byteCountIncS;
      end
      if (loadWriteS) begin
        ramAddressR <= BASE_ADDR + (wrDoneS ? byteCountIncS : byteCountR);
        ramDataInR  <= writeByteS;
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      wrPtrR     <= {PW{1'b0}};
      rdPtrR     <= {PW{1'b0}};
      fifoCountR <= {(PW+1){1'b0}};
    end else begin
      fifoCountR <= countNextS;
      if (flushS) begin
        wrPtrR <= {PW{1'b0}};
        rdPtrR <= {PW{1'b0}};
      end else begin
        if (pushS) wrPtrR <= wrPtrR + PW'(1'b1);
        if (popS)  rdPtrR <= rdPtrR + PW'(1'b1);
      end
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (pushS) fifoMemR[wrPtrR] <= Din;
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] checksumR;
  assign checksum = checksumR;

  // Running sum of bytes the DMA has confirmed this session.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      checksumR <= 8'h00;
    end else if (startS) begin
      checksumR <= 8'h00;
    end else if (wrDoneS) begin
      checksumR <= addByte(checksumR, ramDataInR);
    end
  end
`endif

endmodule

// File: tb/tb_compressed_stream_loader.sv
// Bench for compressed_stream_loader: two instances (base 0x0000 and 0xFFFE) share stimulus;
// a DMA responder pops expected bytes from a scoreboard filled as host words are accepted.
module tb_compressed_stream_loader;

  logic        clk = 1'b0;
  logic        RST, load, interrupt, dinValid, ramDoneWrite;
  logic [15:0] Din;
  logic        dinReady, ramWriteSignal, loading, done, aborted;
  logic [15:0] ramAddress, byteCount;
  logic [7:0]  ramDataIn;
  logic        wDinReady, wRamWriteSignal, wLoading, wDone, wAborted;
  logic [15:0] wRamAddress, wByteCount;
  logic [7:0]  wRamDataIn;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  checksum, wChecksum;
`endif

  compressed_stream_loader #(.BASE_ADDR(16'h0000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .RST(RST), .load(load), .interrupt(interrupt), .Din(Din), .dinValid(dinValid),
    .dinReady(dinReady), .ramAddress(ramAddress), .ramDataIn(ramDataIn),
    .ramWriteSignal(ramWriteSignal), .ramDoneWrite(ramDoneWrite), .byteCount(byteCount),
    .loading(loading), .done(done), .aborted(aborted)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  compressed_stream_loader #(.BASE_ADDR(16'hFFFE), .FIFO_DEPTH(4)) dutWrap (
    .clk(clk), .RST(RST), .load(load), .interrupt(interrupt), .Din(Din), .dinValid(dinValid),
    .dinReady(wDinReady), .ramAddress(wRamAddress), .ramDataIn(wRamDataIn),
    .ramWriteSignal(wRamWriteSignal), .ramDoneWrite(ramDoneWrite), .byteCount(wByteCount),
    .loading(wLoading), .done(wDone), .aborted(wAborted)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(wChecksum)
`endif
  );

  initial forever #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          expAddrQ[$];
  logic [7:0]  expDataQ[$];
  logic [15:0] words[$];
  logic [7:0]  modelSum;
  int          dmaLatency = 3;
  int          dmaCnt = 0;
  bit          latePulseReq = 1'b0;
  int          accepted, hdrIter, doneIter, firstStallAcc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // DMA responder: completes each request after dmaLatency cycles and scores the byte.
  initial begin
    ramDoneWrite = 1'b0;
    forever begin
      @(negedge clk);
      ramDoneWrite = 1'b0;
      if (latePulseReq) begin
        latePulseReq = 1'b0;
        ramDoneWrite = 1'b1;
        dmaCnt = 0;
      end else if (ramWriteSignal) begin
        dmaCnt++;
        if (dmaCnt >= dmaLatency) begin
          ramDoneWrite = 1'b1;
          dmaCnt = 0;
          if (expAddrQ.size() == 0) begin
            check("extra_write", 32'(expAddrQ.size()), 32'd1);
          end else begin
            int         a;
            logic [7:0] d;
            a = expAddrQ.pop_front();
            d = expDataQ.pop_front();
            check("wr_addr", ramAddress, 32'(a[15:0]));
            check("wr_data", ramDataIn, d);
            check("wrap_addr", wRamAddress, 32'(16'(32'hFFFE + a)));
            check("wrap_data", wRamDataIn, d);
          end
        end
      end else begin
        dmaCnt = 0;
      end
    end
  end

  task automatic startSession();
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("start_loading", loading, 1'b1);
    check("start_clears_count", byteCount, 16'h0000);
    check("start_clears_done", done, 1'b0);
  endtask

  // Presents words[] (then junk) with dinValid held high until done or a stop condition.
  task automatic runStream(input int n, input int stopAt, input bit useIrq);
    int idx;
    bit exitOk;
    idx = 0; accepted = 0; hdrIter = -1; doneIter = -1; firstStallAcc = -1;
    modelSum = 8'h00; exitOk = 1'b0;
    for (int it = 0; it < 3000; it++) begin
      if (done) begin
        doneIter = it; exitOk = 1'b1;
        break;
      end
      if (stopAt >= 0 && ramWriteSignal && byteCount == 16'(stopAt)) begin
        if (useIrq) interrupt = 1'b1;
        dinValid = 1'b0; exitOk = 1'b1;
        break;
      end
      Din = (idx < words.size()) ? words[idx] : (16'hEE00 + 16'(idx));
      dinValid = 1'b1;
      if (dinReady) begin
        if (idx == 0) begin
          hdrIter = it;
        end else begin
          for (int b = 0; b < 2; b++) begin
            int         bi;
            logic [7:0] bv;
            bi = 2 * (idx - 1) + b;
            bv = (b == 0) ? Din[15:8] : Din[7:0];
            if (bi < n) begin
              expAddrQ.push_back(bi);
              expDataQ.push_back(bv);
              modelSum = modelSum + bv;
            end
          end
        end
        idx++;
        accepted++;
      end else if (idx > 0 && firstStallAcc < 0 && loading) begin
        firstStallAcc = accepted;
      end
      @(negedge clk);
    end
    check("stream_finished", {31'b0, exitOk}, 32'd1);
    if (stopAt < 0) begin
      for (int k = 0; k < 3; k++) begin
        Din = 16'hBAD0;
        dinValid = 1'b1;
        if (dinReady) accepted++;
        @(negedge clk);
      end
      dinValid = 1'b0;
      check("queue_drained", 32'(expAddrQ.size()), 32'd0);
`ifdef LOADER_CHECKSUM_EN
      check("checksum", checksum, modelSum);
      check("wrap_checksum", wChecksum, modelSum);
`endif
    end
  endtask

  initial begin
    RST = 1'b0; load = 1'b1; dinValid = 1'b1; Din = 16'hFFFF; interrupt = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_write", ramWriteSignal, 1'b0);
    check("rst_ready", dinReady, 1'b0);
    check("rst_count", byteCount, 16'h0000);
    check("rst_addr", ramAddress, 16'h0000);
    check("rst_data", ramDataIn, 8'h00);
    check("rst_flags", {loading, done, aborted}, 3'b000);
    check("rst_wrap_flags", {wDinReady, wRamWriteSignal, wLoading, wDone, wAborted}, 5'b00000);
    load = 1'b0; dinValid = 1'b0;
    @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
    check("idle_after_rst", {loading, dinReady}, 2'b00);

    // Even stream N=4, DMA latency 3.
    startSession();
    dmaLatency = 3;
    words = {16'd4, 16'hA1B2, 16'hC3D4};
    runStream(4, -1, 1'b0);
    check("even_count", byteCount, 16'd4);
    check("even_done", done, 1'b1);
    check("even_accepted", accepted, 32'd3);
    check("even_wrap_count", wByteCount, 16'd4);

    // Odd stream N=3: the 0x44 byte must never be written.
    startSession();
    dmaLatency = 2;
    words = {16'd3, 16'h1122, 16'h3344};
    runStream(3, -1, 1'b0);
    check("odd_count", byteCount, 16'd3);
    check("odd_accepted", accepted, 32'd3);
    check("odd_idle_bus", ramWriteSignal, 1'b0);

    // Backpressure: N=20, slow DMA, host always valid.
    startSession();
    dmaLatency = 10;
    words = {16'd20};
    for (int k = 0; k < 10; k++) words.push_back(16'hA000 + 16'(k * 16'h0111));
    runStream(20, -1, 1'b0);
    check("bp_first_stall", firstStallAcc, 32'd5);
    check("bp_accepted", accepted, 32'd11);
    check("bp_count", byteCount, 16'd20);

    // Abort while the low byte at index 5 is in flight.
    startSession();
    dmaLatency = 4;
    words = {16'd8, 16'h0102, 16'h0304, 16'h0506, 16'h0708};
    runStream(8, 5, 1'b1);
    @(negedge clk);
    interrupt = 1'b0;
    check("abort_write_low", ramWriteSignal, 1'b0);
    check("abort_pulse", aborted, 1'b1);
    check("abort_count", byteCount, 16'd5);
    check("abort_flags", {loading, done, dinReady}, 3'b000);
    expAddrQ.delete();
    expDataQ.delete();
    @(negedge clk);
    check("abort_pulse_end", aborted, 1'b0);
    latePulseReq = 1'b1;
    repeat (3) @(negedge clk);
    check("late_done_count", byteCount, 16'd5);
    check("late_done_idle", {ramWriteSignal, loading}, 2'b00);

    // Clean restart with N=0: done one cycle after the header.
    startSession();
    words = {16'd0};
    runStream(0, -1, 1'b0);
    check("zero_latency", doneIter - hdrIter, 32'd1);
    check("zero_count", byteCount, 16'd0);
    check("zero_accepted", accepted, 32'd1);

    // interrupt and load rise together from DONE: abort wins, edge consumed.
    @(negedge clk);
    load = 1'b1; interrupt = 1'b1;
    @(negedge clk);
    interrupt = 1'b0;
    check("irq_load_abort", {aborted, done, loading}, 3'b100);
    @(negedge clk);
    load = 1'b0;
    check("irq_load_ignored", {loading, dinReady}, 2'b00);

    // Asynchronous reset mid-write drops the request immediately.
    startSession();
    dmaLatency = 50;
    words = {16'd2, 16'h5A5A};
    runStream(2, 0, 1'b0);
    check("pre_rst_write", ramWriteSignal, 1'b1);
    #2;
    RST = 1'b0;
    #1;
    check("async_rst_write", {ramWriteSignal, wRamWriteSignal}, 2'b00);
    check("async_rst_flags", {loading, dinReady}, 2'b00);
    expAddrQ.delete();
    expDataQ.delete();
    @(negedge clk);
    RST = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
